uart_echo_buffer: RTL and testbench

Buffered RX-to-TX echo path between the RX and TX byte interfaces of uart_core, replacing the direct rx_valid->tx_valid wire in board loopback tops. A parametrised FIFO absorbs RX bursts while TX is busy. A runtime mode selects byte echo, line echo (release on terminator byte) or flush. Overflow drops are counted for debug.

---
 rtl/uart_echo_buffer.sv | 125 ++++++++++++
 tb/tb_uart_echo_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_buffer.sv
// Buffered RX-to-TX echo path: a FIFO absorbs RX bursts and one output register
// drives TX. The mode selects byte echo, line echo, hold or flush; drops are counted.
module uart_echo_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int OVF_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 cfg_mode,
    input  logic [DATA_W-1:0]          cfg_term,
    input  logic                       ovf_clr,
    input  logic                       rx_valid,
    input  logic [DATA_W-1:0]          rx_data,
    output logic                       tx_valid,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       ovf_pulse,
    output logic [OVF_W-1:0]           ovf_cnt
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] MODE_BYTE  = 2'b00;
    localparam logic [1:0] MODE_LINE  = 2'b01;
    localparam logic [1:0] MODE_HOLD  = 2'b10;
    localparam logic [1:0] MODE_FLUSH = 2'b11;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              force_q;

    logic              empty;
    logic              full;
    logic              flush;
    logic              release_ok;
    logic              load;
    logic              push;
    logic              drop;
    logic              push_term;
    logic              pop_term;
    logic [DATA_W-1:0] head;

    always_comb begin
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        flush      = (cfg_mode == MODE_FLUSH);
        head       = mem[rd_ptr[PTR_W-1:0]];
        release_ok = 1'b0;
        case (cfg_mode)
            MODE_BYTE:  release_ok = 1'b1;
            MODE_LINE:  release_ok = (pending != '0) || force_q;
            MODE_HOLD:  release_ok = 1'b0;
            MODE_FLUSH: release_ok = 1'b0;
            default:    release_ok = 1'b0;
        endcase
        // A full FIFO drops even if a pop frees a slot this same cycle.
        load      = (!tx_valid || tx_ready) && !empty && release_ok && !flush;
        push      = rx_valid && !full && !flush;
        drop      = rx_valid && full && !flush;
        push_term = push && (rx_data == cfg_term);
        pop_term  = load && (head == cfg_term);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pending   <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            ovf_pulse <= 1'b0;
            ovf_cnt   <= '0;
            force_q   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level   <= '0;
                pending <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
                end
                if (load) begin
                    rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
                end
                level   <= level + LVL_W'(push) - LVL_W'(load);
                pending <= pending + LVL_W'(push_term) - LVL_W'(pop_term);
            end

            if (load) begin
                tx_valid <= 1'b1;
                tx_data  <= head;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end

            ovf_pulse <= drop;
            if (ovf_clr) begin
                ovf_cnt <= '0;
            end else if (drop && (ovf_cnt != {OVF_W{1'b1}})) begin
                ovf_cnt <= ovf_cnt + OVF_W'(1);
            end

            // Line mode with a full FIFO and no terminator would never release.
            if ((cfg_mode != MODE_LINE) || empty) begin
                force_q <= 1'b0;
            end else if (full && (pending == '0)) begin
                force_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_echo_buffer.sv
// Scoreboard bench for uart_echo_buffer: a queue-based reference model predicts
// occupancy and emitted bytes; a separate monitor pops expectations on each TX handshake.
module tb_uart_echo_buffer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int OVF_W  = 16;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        cfg_mode = 2'b00;
    logic [DATA_W-1:0] cfg_term = 8'h0D;
    logic              ovf_clr = 1'b0;
    logic              rx_valid = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready = 1'b0;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  pending;
    logic              ovf_pulse;
    logic [OVF_W-1:0]  ovf_cnt;

    uart_echo_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_term(cfg_term),
        .ovf_clr(ovf_clr), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .level(level), .pending(pending), .ovf_pulse(ovf_pulse), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    int pulse_cnt = 0;

    // Reference model: buffered bytes, output beat, overflow state.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              m_ov = 1'b0;
    logic [DATA_W-1:0] m_od = '0;
    logic              m_force = 1'b0;
    logic              m_pulse = 1'b0;
    logic [OVF_W-1:0]  m_cnt = '0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int term_count();
        int c = 0;
        foreach (mq[i]) if (mq[i] == cfg_term) c++;
        return c;
    endfunction

    always @(posedge clk) begin : model
        bit full, flush, rel, load, drop;
        int pend;
        logic [DATA_W-1:0] head;
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            m_ov = 1'b0; m_od = '0; m_force = 1'b0; m_pulse = 1'b0; m_cnt = '0;
        end else begin
            full  = (mq.size() == DEPTH);
            flush = (cfg_mode == 2'b11);
            pend  = term_count();
            rel   = (cfg_mode == 2'b00) || (cfg_mode == 2'b01 && (pend > 0 || m_force));
            load  = (!m_ov || tx_ready) && (mq.size() > 0) && rel && !flush;
            drop  = rx_valid && full && !flush;
            if (cfg_mode != 2'b01 || mq.size() == 0) m_force = 1'b0;
            else if (full && pend == 0) m_force = 1'b1;
            if (load) begin
                head = mq.pop_front();
                m_ov = 1'b1;
                m_od = head;
                exp_q.push_back(head);
            end else if (tx_ready) begin
                m_ov = 1'b0;
            end
            if (flush) mq.delete();
            else if (rx_valid && !full) mq.push_back(rx_data);
            m_pulse = drop;
            if (ovf_clr) m_cnt = '0;
            else if (drop && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end
        #1;
        check("level", level, mq.size());
        check("pending", pending, term_count());
        check("tx_valid", tx_valid, m_ov);
        check("tx_data", tx_data, m_od);
        check("ovf_pulse", ovf_pulse, m_pulse);
        check("ovf_cnt", ovf_cnt, m_cnt);
    end

    // Monitor: sample after the driver settles, so values are those the next edge consumes.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && ovf_pulse) pulse_cnt++;
            if (rst_n && tx_valid && tx_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got %0h expected no beat at %0t", tx_data, $time);
                end else begin
                    check("tx_beat", tx_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [DATA_W-1:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int hs0, p0;
        logic [DATA_W-1:0] echo_bytes [3];
        echo_bytes[0] = 8'h41; echo_bytes[1] = 8'h42; echo_bytes[2] = 8'h43;

        idle(3);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_level", level, 0);
        rst_n = 1'b1;
        idle(2);

        // Byte echo with latency check.
        cfg_mode = 2'b00;
        tx_ready = 1'b1;
        hs0 = hs_cnt;
        for (int i = 0; i < 3; i++) begin
            send_byte(echo_bytes[i]);
            #1 check("lat_cycle1", tx_valid, 0);
            @(negedge clk);
            #1 check("lat_cycle2", tx_valid, 1);
            check("lat_data", tx_data, echo_bytes[i]);
            idle(8);
        end
        check("echo_count", hs_cnt - hs0, 3);
        check("echo_level", level, 0);

        // Overflow with TX stalled.
        tx_ready = 1'b0;
        p0 = pulse_cnt;
        for (int i = 0; i < 20; i++) send_byte(8'(8'h60 + i));
        idle(3);
        check("ovf_level", level, 16);
        check("ovf_cnt3", ovf_cnt, 3);
        check("ovf_pulses", pulse_cnt - p0, 3);
        hs0 = hs_cnt;
        tx_ready = 1'b1;
        idle(30);
        check("ovf_drain", hs_cnt - hs0, 17);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        #1 check("ovf_clr", ovf_cnt, 0);
        idle(2);

        // Line echo.
        cfg_mode = 2'b01;
        hs0 = hs_cnt;
        send_byte(8'h61);
        send_byte(8'h62);
        idle(5);
        check("line_hold_valid", tx_valid, 0);
        check("line_hold_level", level, 2);
        send_byte(8'h0D);
        #1 check("line_pending", pending, 1);
        idle(10);
        check("line_count", hs_cnt - hs0, 3);
        check("line_pending0", pending, 0);

        // Line mode deadlock escape.
        hs0 = hs_cnt;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i));
        #1 check("force_full", level, 16);
        idle(40);
        check("force_drain", hs_cnt - hs0, 16);
        check("force_level", level, 0);

        // Flush while a beat is held.
        cfg_mode = 2'b00;
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'(8'h70 + i));
        idle(2);
        check("flush_pre_level", level, 5);
        cfg_mode = 2'b11;
        @(negedge clk);
        #1 check("flush_level", level, 0);
        check("flush_held", tx_valid, 1);
        hs0 = hs_cnt;
        send_byte(8'h99);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        idle(3);
        tx_ready = 1'b1;
        idle(5);
        check("flush_one", hs_cnt - hs0, 1);
        check("flush_no_ovf", ovf_cnt, 0);
        cfg_mode = 2'b00;
        idle(3);

        // Randomized traffic across modes.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                int r;
                r = $urandom_range(0, 9);
                cfg_mode = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            end
            tx_ready = ($urandom_range(0, 2) != 0);
            rx_valid = $urandom_range(0, 1);
            rx_data  = ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom);
            ovf_clr  = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        ovf_clr  = 1'b0;
        cfg_mode = 2'b00;
        tx_ready = 1'b1;
        idle(40);
        check("rand_level", level, 0);
        check("rand_exp_empty", exp_q.size(), 0);

        // Asynchronous reset mid-burst.
        tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) send_byte(8'(8'hA0 + i));
        #3 rst_n = 1'b0;
        #1;
        check("arst_tx_valid", tx_valid, 0);
        check("arst_tx_data", tx_data, 0);
        check("arst_level", level, 0);
        check("arst_pending", pending, 0);
        check("arst_ovf_cnt", ovf_cnt, 0);
        check("arst_ovf_pulse", ovf_pulse, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        hs0 = hs_cnt;
        send_byte(8'h55);
        idle(5);
        check("post_rst_echo", hs_cnt - hs0, 1);
        check("final_exp_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
